// File: rtl/modmul_solinas_pipe.sv
// ---------------------------------------------------------------------------
// modmul_solinas_pipe
//
// Three-stage pipelined modular multiplier for CRYSTALS-Dilithium,
// q = 8380417 = 2^23 - 2^13 + 1. It sits between the NTT butterfly / operand
// fetch (upstream) and coefficient writeback (downstream).
//
//   S1 (mul)     : p = a * b, 46-bit unsigned product
//   S2 (fold)    : Solinas reduction using 2^23 == 2^13 - 1 (mod q), giving a
//                  26-bit signed partial residue r in (-(2^23+2^13), 3*2^23)
//   S3 (correct) : picks whichever of r, r+q, r-q, r-2q, r-3q lies in [0, q)
//
// Latency is three register stages. Throughput is one operation per cycle.
// Each stage advances when its successor is empty or is advancing itself.
// in_ready therefore has a combinational path from out_ready, so releasing
// backpressure does not create a bubble.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; drops everything in flight
//   flush      synchronous clear of all in-flight operations (overrides out_ready)
//   in_valid   operand pair valid
//   in_ready   stage 1 can accept this cycle (reads 1 during flush)
//   in_a/in_b  operands, expected in [0, q)
//   in_tag     opaque sideband tag, returned unchanged with the result
//   out_valid  result valid; out_r/out_tag hold while stalled
//   out_ready  consumer accepts the result
//   out_r      (a*b) mod q, canonical
//   out_tag    tag belonging to out_r
//   busy       any stage holds a valid operation
// ---------------------------------------------------------------------------
module modmul_solinas_pipe #(
    parameter int unsigned Q     = 32'd8380417,
    parameter int unsigned W     = 32'd23,
    parameter int unsigned TAG_W = 32'd8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_r,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    // Product width, folded-residue width and correction-arithmetic width.
    localparam int unsigned PW = 2 * W;
    localparam int unsigned RW = 32'd26;
    localparam int unsigned CW = 32'd28;

    localparam logic signed [CW-1:0] Q1_C = CW'(Q);
    localparam logic signed [CW-1:0] Q2_C = CW'(2 * Q);
    localparam logic signed [CW-1:0] Q3_C = CW'(3 * Q);

    // -----------------------------------------------------------------------
    // Solinas fold of the 46-bit product.
    // Let p = t + 2^23*A with A = p[45:23]. Then 2^23 == 2^13 - 1 gives
    //   p == t + (A << 13) - A.
    // (A << 13) still overflows bit 23. Splitting A = p[32:23] + 2^10*p[45:33]
    // and folding once more yields
    //   r = t + s1 + s2 + s3 - d1 - d2 - d3.
    // The true value of r fits comfortably in 26 signed bits. The modular
    // wrap of the unsigned subtraction therefore lands exactly on the right
    // two's-complement pattern.
    // -----------------------------------------------------------------------
    function automatic logic signed [RW-1:0] solinas_fold(input logic [PW-1:0] p);
        logic [RW-1:0] add_s;
        logic [RW-1:0] sub_s;
        add_s = {3'b000, p[22:0]}
              + {3'b000, p[32:23], 13'd0}
              + {3'b000, p[42:33], 13'd0}
              + {10'd0, p[45:43], 13'd0};
        sub_s = {3'b000, p[45:23]}
              + {13'd0, p[45:33]}
              + {23'd0, p[45:43]};
        return signed'(add_s - sub_s);
    endfunction

    // True when a correction candidate is the canonical residue.
    function automatic logic in_canon(input logic signed [CW-1:0] c);
        return (c[CW-1] == 1'b0) && (c < Q1_C);
    endfunction

    // -----------------------------------------------------------------------
    // Final correction. At most one candidate lies in [0, q), so the order
    // of the chain does not matter. Out-of-contract operands can leave no
    // candidate in range; zero is returned so the pipeline keeps moving.
    // -----------------------------------------------------------------------
    function automatic logic [W-1:0] canon_select(input logic signed [RW-1:0] r);
        logic signed [CW-1:0] rx_s;
        logic signed [CW-1:0] c_add_q_s;
        logic signed [CW-1:0] c_sub_q_s;
        logic signed [CW-1:0] c_sub_2q_s;
        logic signed [CW-1:0] c_sub_3q_s;
        logic [W-1:0]         res_s;
        rx_s       = {{(CW - RW){r[RW-1]}}, r};
        c_add_q_s  = rx_s + Q1_C;
        c_sub_q_s  = rx_s - Q1_C;
        c_sub_2q_s = rx_s - Q2_C;
        c_sub_3q_s = rx_s - Q3_C;
        if (in_canon(rx_s)) begin
            res_s = rx_s[W-1:0];
        end else if (in_canon(c_add_q_s)) begin
            res_s = c_add_q_s[W-1:0];
        end else if (in_canon(c_sub_q_s)) begin
            res_s = c_sub_q_s[W-1:0];
        end else if (in_canon(c_sub_2q_s)) begin
            res_s = c_sub_2q_s[W-1:0];
        end else if (in_canon(c_sub_3q_s)) begin
            res_s = c_sub_3q_s[W-1:0];
        end else begin
            res_s = {W{1'b0}};
        end
        return res_s;
    endfunction

    // Stage valid bits.
    logic s1_v_q, s1_v_d;
    logic s2_v_q, s2_v_d;
    logic s3_v_q, s3_v_d;

    // Stage payloads.
    logic        [PW-1:0]    s1_p_q,   s1_p_d;
    logic        [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic signed [RW-1:0]    s2_r_q,   s2_r_d;
    logic        [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic        [W-1:0]     s3_r_q,   s3_r_d;
    logic        [TAG_W-1:0] s3_tag_q, s3_tag_d;

    // Handshake terms.
    logic          ld1_s, ld2_s, ld3_s;
    logic          in_ready_s;
    logic [PW-1:0] prod_s;

    assign prod_s = PW'(in_a) * PW'(in_b);

    // Stage load enables; each stage loads when its successor is empty or draining.
    always_comb begin
        ld3_s      = s2_v_q & (~s3_v_q | out_ready);
        ld2_s      = s1_v_q & (~s2_v_q | ld3_s);
        in_ready_s = flush | ~s1_v_q | ld2_s;
        ld1_s      = in_valid & in_ready_s & ~flush;
    end

    // Next-state of the valid bits; flush empties the whole pipe.
    always_comb begin
        s1_v_d = s1_v_q;
        s2_v_d = s2_v_q;
        s3_v_d = s3_v_q;
        if (flush) begin
            s1_v_d = 1'b0;
            s2_v_d = 1'b0;
            s3_v_d = 1'b0;
        end else begin
            if (ld1_s) begin
                s1_v_d = 1'b1;
            end else if (ld2_s) begin
                s1_v_d = 1'b0;
            end else begin
                s1_v_d = s1_v_q;
            end

            if (ld2_s) begin
                s2_v_d = 1'b1;
            end else if (ld3_s) begin
                s2_v_d = 1'b0;
            end else begin
                s2_v_d = s2_v_q;
            end

            if (ld3_s) begin
                s3_v_d = 1'b1;
            end else if (out_ready) begin
                s3_v_d = 1'b0;
            end else begin
                s3_v_d = s3_v_q;
            end
        end
    end

    // Next-state of the stage payloads: multiply, fold, correct.
    always_comb begin
        s1_p_d   = s1_p_q;
        s1_tag_d = s1_tag_q;
        s2_r_d   = s2_r_q;
        s2_tag_d = s2_tag_q;
        s3_r_d   = s3_r_q;
        s3_tag_d = s3_tag_q;

        if (ld1_s) begin
            s1_p_d   = prod_s;
            s1_tag_d = in_tag;
        end else begin
            s1_p_d   = s1_p_q;
            s1_tag_d = s1_tag_q;
        end

        if (ld2_s) begin
            s2_r_d   = solinas_fold(s1_p_q);
            s2_tag_d = s1_tag_q;
        end else begin
            s2_r_d   = s2_r_q;
            s2_tag_d = s2_tag_q;
        end

        if (ld3_s) begin
            s3_r_d   = canon_select(s2_r_q);
            s3_tag_d = s2_tag_q;
        end else begin
            s3_r_d   = s3_r_q;
            s3_tag_d = s3_tag_q;
        end
    end

    // Valid-bit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            s3_v_q <= 1'b0;
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
            s3_v_q <= s3_v_d;
        end
    end

    // Payload registers; cleared on reset so out_r/out_tag read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_p_q   <= {PW{1'b0}};
            s1_tag_q <= {TAG_W{1'b0}};
            s2_r_q   <= {RW{1'b0}};
            s2_tag_q <= {TAG_W{1'b0}};
            s3_r_q   <= {W{1'b0}};
            s3_tag_q <= {TAG_W{1'b0}};
        end else begin
            s1_p_q   <= s1_p_d;
            s1_tag_q <= s1_tag_d;
            s2_r_q   <= s2_r_d;
            s2_tag_q <= s2_tag_d;
            s3_r_q   <= s3_r_d;
            s3_tag_q <= s3_tag_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = s3_v_q;
    assign out_r     = s3_r_q;
    assign out_tag   = s3_tag_q;
    assign busy      = s1_v_q | s2_v_q | s3_v_q;

endmodule

// File: tb/tb_modmul_solinas_pipe.sv
// ---------------------------------------------------------------------------
// Testbench for modmul_solinas_pipe.
//
// The driver offers operations and pushes each expected response into a
// scoreboard queue the moment the handshake is sampled. Expected responses
// come from plain (a*b) % q arithmetic, or from fixed known answers. A
// separate monitor pops and compares whenever the DUT hands over a result.
// A third process drives out_ready according to the current mode.
//
// Timing: inputs change 2 time units after the rising edge, out_ready
// changes 1 unit after it, and everything is sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_modmul_solinas_pipe;

    localparam int unsigned Q  = 32'd8380417;
    localparam int unsigned W  = 32'd23;
    localparam int unsigned TW = 32'd8;
    localparam logic [W-1:0] QM1 = W'(Q - 32'd1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_r;
    logic [TW-1:0] out_tag;
    logic          busy;

    modmul_solinas_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  r;
        logic [TW-1:0] tag;
        bit            chk_r;
        bit            chk_lat;
        longint        acc;     // index of the accepting rising edge
    } exp_t;

    exp_t          sb[$];
    int            errors = 0;
    int            checks = 0;
    longint        cyc = 0;     // rising edges seen so far
    int            or_mode = 1; // 0: hold off, 1: always ready, 2: random
    bit            nogap = 1'b0;
    logic [TW-1:0] tag_ctr = '0;

    // Reference: plain modular arithmetic on wide integers.
    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned p;
        p = 64'(a) * 64'(b);
        return W'(p % 64'(Q));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_quiet_outputs(input string tag_s);
        chk({tag_s, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag_s, "_out_r"},     64'(out_r),     64'd0);
        chk({tag_s, "_out_tag"},   64'(out_tag),   64'd0);
        chk({tag_s, "_busy"},      64'(busy),      64'd0);
        chk({tag_s, "_in_ready"},  64'(in_ready),  64'd1);
    endtask

    always @(posedge clk) cyc = cyc + 64'sd1;

    // Consumer: out_ready according to mode.
    always @(posedge clk) begin
        #1;
        case (or_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(1));
        endcase
    end

    // Monitor: compares handed-over results and checks stability under stall.
    logic          prev_stall = 1'b0;
    logic [W-1:0]  prev_r = '0;
    logic [TW-1:0] prev_tag = '0;
    exp_t          mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_r",     64'(out_r),     64'(prev_r));
                chk("stall_tag",   64'(out_tag),   64'(prev_tag));
            end
            if (nogap && sb.size() > 0) begin
                if (sb[0].acc + 64'sd3 <= cyc + 64'sd1) chk("no_gap", 64'(out_valid), 64'd1);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got r=%0d tag=%0d, expected no result", out_r, out_tag);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.chk_r) chk("result", 64'(out_r), 64'(mon_e.r));
                    chk("tag", 64'(out_tag), 64'(mon_e.tag));
                    if (mon_e.chk_lat) chk("latency", 64'(cyc + 64'sd1 - mon_e.acc), 64'd3);
                end
            end
            if (flush) sb.delete();
            prev_stall = out_valid && !out_ready && !flush;
            prev_r     = out_r;
            prev_tag   = out_tag;
        end
    end

    // Offer one operation until it is accepted; called and returns at posedge+2.
    task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_r, input bit chk_r, input bit chk_lat);
        exp_t e;
        bit   acc_ok;
        acc_ok   = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = tag_ctr;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (in_ready && !flush) begin
                e.r       = exp_r;
                e.tag     = tag_ctr;
                e.chk_r   = chk_r;
                e.chk_lat = chk_lat;
                e.acc     = cyc + 64'sd1;
                sb.push_back(e);
                acc_ok = 1'b1;
            end
            @(posedge clk);
            #2;
            if (acc_ok) break;
        end
        in_valid = 1'b0;
        tag_ctr++;
        if (!acc_ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 64 cycles");
        end
    endtask

    task automatic offer_rand(input bit chk_lat);
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = W'($urandom_range(Q - 32'd1));
        b = W'($urandom_range(Q - 32'd1));
        offer(a, b, ref_mul(a, b), 1'b1, chk_lat);
    endtask

    // Wait for scoreboard and pipe to empty; ends at posedge+2.
    task automatic drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;

        // Reset state.
        repeat (2) @(negedge clk);
        chk_quiet_outputs("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Known answers with exact latency.
        nogap = 1'b1;
        offer(QM1,   QM1,          23'd1, 1'b1, 1'b1);
        offer(23'd2, 23'd4190209,  23'd1, 1'b1, 1'b1);
        offer(23'd1, QM1,          QM1,   1'b1, 1'b1);
        offer(23'd0, QM1,          23'd0, 1'b1, 1'b1);
        offer(QM1,   23'd1,        QM1,   1'b1, 1'b1);
        drain();

        // Full-rate random stream: one result per cycle, latency 3.
        repeat (10000) offer_rand(1'b1);
        drain();
        nogap = 1'b0;

        // Backpressure: three ops fit, the fourth stalls.
        or_mode = 0;
        @(posedge clk);
        #2;
        repeat (3) offer_rand(1'b0);
        a        = W'($urandom_range(Q - 32'd1));
        b        = W'($urandom_range(Q - 32'd1));
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = tag_ctr;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_busy",     64'(busy),     64'd1);
        end
        or_mode = 1;
        @(posedge clk);
        #2;
        nogap = 1'b1;
        offer(a, b, ref_mul(a, b), 1'b1, 1'b1);
        drain();
        nogap = 1'b0;

        // Random consumer readiness, occasional idle cycles and out-of-range operands.
        or_mode = 2;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(49) == 0) begin
                a = W'($urandom_range(32'h7FFFFF, Q));
                b = W'($urandom_range(32'h7FFFFF));
                offer(a, b, '0, 1'b0, 1'b0);
            end else begin
                offer_rand(1'b0);
            end
            if ($urandom_range(3) == 0) begin
                @(posedge clk);
                #2;
            end
        end
        or_mode = 1;
        drain();

        // Asynchronous reset mid-burst.
        or_mode = 2;
        repeat (6) offer_rand(1'b0);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk_quiet_outputs("midreset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("postreset_busy",      64'(busy),      64'd0);
        chk("postreset_out_valid", 64'(out_valid), 64'd0);
        or_mode = 1;
        @(posedge clk);
        #2;
        nogap = 1'b1;
        offer(QM1, QM1, 23'd1, 1'b1, 1'b1);
        drain();
        nogap = 1'b0;

        // Flush mid-burst; the input offered during flush is discarded.
        or_mode = 2;
        repeat (6) offer_rand(1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_a     = W'($urandom_range(Q - 32'd1));
        in_b     = W'($urandom_range(Q - 32'd1));
        in_tag   = tag_ctr;
        tag_ctr++;
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #2;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("postflush_busy",      64'(busy),      64'd0);
        chk("postflush_out_valid", 64'(out_valid), 64'd0);
        or_mode = 1;
        @(posedge clk);
        #2;
        nogap = 1'b1;
        offer(23'd2, 23'd4190209, 23'd1, 1'b1, 1'b1);
        repeat (20) offer_rand(1'b1);
        drain();
        nogap = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
